// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle; perf counters appear only with PIPE_HAZARD_PERF_EN.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned REG_W = 5
`ifdef PIPE_HAZARD_PERF_EN
  , parameter int unsigned CNT_W = 32
`endif
);
    logic             IDEX_MemRead_i;
    logic [REG_W-1:0] IDEX_RDaddr_i;
    logic [REG_W-1:0] IFID_RS1addr_i;
    logic [REG_W-1:0] IFID_RS2addr_i;
    logic             Branch_taken_i;
    logic             MemStall_i;
    logic             PCWrite_o;
    logic             IFID_Write_o;
    logic             IFID_Flush_o;
    logic             IDEX_Bubble_o;
    logic             Stall_o;
    logic             Timeout_o;
    logic [1:0]       State_o;
`ifdef PIPE_HAZARD_PERF_EN
    logic [CNT_W-1:0] StallCnt_o;
    logic [CNT_W-1:0] FlushCnt_o;
`endif

    modport master (
        output IDEX_MemRead_i, IDEX_RDaddr_i, IFID_RS1addr_i, IFID_RS2addr_i,
               Branch_taken_i, MemStall_i,
        input  PCWrite_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o, Stall_o,
               Timeout_o, State_o
`ifdef PIPE_HAZARD_PERF_EN
             , StallCnt_o, FlushCnt_o
`endif
    );

    modport slave (
        input  IDEX_MemRead_i, IDEX_RDaddr_i, IFID_RS1addr_i, IFID_RS2addr_i,
               Branch_taken_i, MemStall_i,
        output PCWrite_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o, Stall_o,
               Timeout_o, State_o
`ifdef PIPE_HAZARD_PERF_EN
             , StallCnt_o, FlushCnt_o
`endif
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline hazard controller: load-use, taken branch, memory wait with watchdog.
// Optional perf counters enabled by defining PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic               clk_i,
    input  logic               rst_i,
    pipe_hazard_ctrl_if.slave  hz
);
    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
    logic                hazard;
    logic                pc_write, ifid_write, ifid_flush, idex_bubble, stall, timeout;

    assign hazard = hz.IDEX_MemRead_i && (hz.IDEX_RDaddr_i != '0) &&
                    ((hz.IDEX_RDaddr_i == hz.IFID_RS1addr_i) ||
                     (hz.IDEX_RDaddr_i == hz.IFID_RS2addr_i));

    // State register and memory-wait watchdog counter
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = RUN;
        wait_nxt  = wait_cnt;
        case (state)
            RUN: begin
                if (hz.MemStall_i) begin
                    state_nxt = MEM_WAIT;
                    wait_nxt  = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (hz.MemStall_i) begin
                    if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
                        state_nxt = FAULT;
                    end else begin
                        state_nxt = MEM_WAIT;
                        wait_nxt  = wait_cnt + WAIT_W'(1);
                    end
                end else begin
                    wait_nxt = '0;
                end
            end
            FAULT:   state_nxt = FAULT;
            default: state_nxt = RUN;
        endcase
    end

    // Output logic: combinational so the pipeline reacts in the same cycle
    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        stall       = 1'b0;
        timeout     = 1'b0;
        if (rst_i) begin
            if (state == FAULT) begin
                stall   = 1'b1;
                timeout = 1'b1;
            end else if (hz.MemStall_i) begin
                stall = 1'b1;
            end else if (hazard) begin
                idex_bubble = 1'b1;
            end else if (hz.Branch_taken_i) begin
                pc_write   = 1'b1;
                ifid_write = 1'b1;
                ifid_flush = 1'b1;
            end else begin
                pc_write   = 1'b1;
                ifid_write = 1'b1;
            end
        end
    end

    assign hz.PCWrite_o     = pc_write;
    assign hz.IFID_Write_o  = ifid_write;
    assign hz.IFID_Flush_o  = ifid_flush;
    assign hz.IDEX_Bubble_o = idex_bubble;
    assign hz.Stall_o       = stall;
    assign hz.Timeout_o     = timeout;
    assign hz.State_o       = state;

`ifdef PIPE_HAZARD_PERF_EN
    localparam int unsigned CNT_W = $bits(hz.StallCnt_o);

    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             stall_evt;

    assign stall_evt = !pc_write && ((state == RUN) || (state == MEM_WAIT));

    // Saturating performance counters
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_evt && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (ifid_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign hz.StallCnt_o = stall_cnt;
    assign hz.FlushCnt_o = flush_cnt;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a cycle-level reference model and literal spot checks.
module tb_pipe_hazard_ctrl;
    localparam int unsigned T = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if hz_if ();

    pipe_hazard_ctrl #(.MEM_TIMEOUT(T)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .hz    (hz_if.slave)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit started     = 1'b0;

    // Model state: consecutive stalled cycles, sticky fault, and whether last cycle stalled
    int          m_run  = 0;
    bit          m_fault = 1'b0;
    bit          m_prev  = 1'b0;
    int unsigned m_scnt  = 0;
    int unsigned m_fcnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit mr, input int rd, input int r1, input int r2,
                         input bit br, input bit ms);
        @(posedge clk);
        #1;
        rst                  = r;
        hz_if.IDEX_MemRead_i = mr;
        hz_if.IDEX_RDaddr_i  = 5'(rd);
        hz_if.IFID_RS1addr_i = 5'(r1);
        hz_if.IFID_RS2addr_i = 5'(r2);
        hz_if.Branch_taken_i = br;
        hz_if.MemStall_i     = ms;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    // Reference model and per-cycle comparison
    always @(negedge clk) begin
        if (started) begin : cmp
            bit       hzd;
            bit       e_pc, e_ifw, e_fl, e_bub, e_st, e_to;
            bit [1:0] e_state;
            hzd = hz_if.IDEX_MemRead_i && (hz_if.IDEX_RDaddr_i != 0) &&
                  ((hz_if.IDEX_RDaddr_i == hz_if.IFID_RS1addr_i) ||
                   (hz_if.IDEX_RDaddr_i == hz_if.IFID_RS2addr_i));
            {e_pc, e_ifw, e_fl, e_bub, e_st, e_to} = 6'b0;
            e_state = 2'd0;
            if (rst) begin
                if (m_fault) begin
                    e_st = 1'b1; e_to = 1'b1; e_state = 2'd2;
                end else begin
                    e_state = m_prev ? 2'd1 : 2'd0;
                    if (hz_if.MemStall_i)          e_st = 1'b1;
                    else if (hzd)                  e_bub = 1'b1;
                    else if (hz_if.Branch_taken_i) begin e_pc = 1'b1; e_ifw = 1'b1; e_fl = 1'b1; end
                    else                           begin e_pc = 1'b1; e_ifw = 1'b1; end
                end
            end
            chk("pcwrite",  32'(hz_if.PCWrite_o),     32'(e_pc));
            chk("ifid_wr",  32'(hz_if.IFID_Write_o),  32'(e_ifw));
            chk("flush",    32'(hz_if.IFID_Flush_o),  32'(e_fl));
            chk("bubble",   32'(hz_if.IDEX_Bubble_o), 32'(e_bub));
            chk("stall",    32'(hz_if.Stall_o),       32'(e_st));
            chk("timeout",  32'(hz_if.Timeout_o),     32'(e_to));
            chk("state",    32'(hz_if.State_o),       32'(e_state));
`ifdef PIPE_HAZARD_PERF_EN
            chk("stallcnt", 32'(hz_if.StallCnt_o), rst ? m_scnt : 32'd0);
            chk("flushcnt", 32'(hz_if.FlushCnt_o), rst ? m_fcnt : 32'd0);
`endif
            if (!rst) begin
                m_run = 0; m_fault = 1'b0; m_prev = 1'b0; m_scnt = 0; m_fcnt = 0;
            end else if (!m_fault) begin
                if (!e_pc) m_scnt++;
                if (e_fl)  m_fcnt++;
                if (hz_if.MemStall_i) begin
                    m_run++;
                    m_prev = 1'b1;
                    if (m_run == int'(T) + 1) m_fault = 1'b1;
                end else begin
                    m_run  = 0;
                    m_prev = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin : stim
        rst = 1'b1;
        hz_if.IDEX_MemRead_i = 1'b0;
        hz_if.IDEX_RDaddr_i  = '0;
        hz_if.IFID_RS1addr_i = '0;
        hz_if.IFID_RS2addr_i = '0;
        hz_if.Branch_taken_i = 1'b0;
        hz_if.MemStall_i     = 1'b0;
        #1 rst = 1'b0;
        started = 1'b1;

        drive(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0);
        chk("lit_rst_pc",    32'(hz_if.PCWrite_o),    32'd0);
        chk("lit_rst_flush", 32'(hz_if.IFID_Flush_o), 32'd0);
        chk("lit_rst_state", 32'(hz_if.State_o),      32'd0);

        idle();
        chk("lit_run_pc", 32'(hz_if.PCWrite_o), 32'd1);

        // Load-use on x5
        drive(1'b1, 1'b1, 5, 5, 0, 1'b0, 1'b0);
        chk("lit_lu_bubble", 32'(hz_if.IDEX_Bubble_o), 32'd1);
        chk("lit_lu_pc",     32'(hz_if.PCWrite_o),     32'd0);
        idle();
        chk("lit_lu_after",  32'(hz_if.PCWrite_o),     32'd1);

        // Load to x0 never stalls
        drive(1'b1, 1'b1, 0, 3, 0, 1'b0, 1'b0);
        chk("lit_x0_pc", 32'(hz_if.PCWrite_o), 32'd1);

        // Taken branch
        drive(1'b1, 1'b0, 0, 0, 0, 1'b1, 1'b0);
        chk("lit_br_flush", 32'(hz_if.IFID_Flush_o), 32'd1);
        chk("lit_br_pc",    32'(hz_if.PCWrite_o),    32'd1);
        idle();
`ifdef PIPE_HAZARD_PERF_EN
        chk("lit_flushcnt", 32'(hz_if.FlushCnt_o), 32'd1);
        chk("lit_stallcnt", 32'(hz_if.StallCnt_o), 32'd1);
`endif

        // Four-cycle memory stall, branch held during the stall is ignored
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 0, 0, 0, i == 2, 1'b1);
            chk("lit_ms_stall", 32'(hz_if.Stall_o),      32'd1);
            chk("lit_ms_flush", 32'(hz_if.IFID_Flush_o), 32'd0);
            if (i > 0) chk("lit_ms_state", 32'(hz_if.State_o), 32'd1);
        end
        idle();
        chk("lit_ms_end_pc", 32'(hz_if.PCWrite_o), 32'd1);
        idle();
        chk("lit_ms_run", 32'(hz_if.State_o), 32'd0);

        // Hazard and branch together: stall first, flush next cycle
        drive(1'b1, 1'b1, 7, 0, 7, 1'b1, 1'b0);
        chk("lit_hb_bubble", 32'(hz_if.IDEX_Bubble_o), 32'd1);
        chk("lit_hb_flush",  32'(hz_if.IFID_Flush_o),  32'd0);
        drive(1'b1, 1'b0, 0, 0, 0, 1'b1, 1'b0);
        chk("lit_hb_flush2", 32'(hz_if.IFID_Flush_o),  32'd1);

        // Asynchronous reset out of MEM_WAIT
        drive(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b1);
        chk("lit_ar_wait", 32'(hz_if.State_o), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("lit_ar_state", 32'(hz_if.State_o), 32'd0);
        chk("lit_ar_stall", 32'(hz_if.Stall_o), 32'd0);
        drive(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1);
        idle();

        // Watchdog: 20-cycle stall
        for (int i = 1; i <= 20; i++) begin
            drive(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b1);
            if (i == 16) chk("lit_wd_c16", 32'(hz_if.Timeout_o), 32'd0);
            if (i == 17) chk("lit_wd_c17", 32'(hz_if.State_o),   32'd2);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 0, 0, 0, 1'b1, 1'b0);
            chk("lit_wd_sticky", 32'(hz_if.Timeout_o), 32'd1);
            chk("lit_wd_pc",     32'(hz_if.PCWrite_o), 32'd0);
        end
        drive(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        chk("lit_wd_clear", 32'(hz_if.Timeout_o), 32'd0);
        idle();
        chk("lit_wd_run", 32'(hz_if.PCWrite_o), 32'd1);

        started = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
